// File: rtl/rf_write_arbiter_if.sv
// Bundle for the register-file write arbiter: two writeback requesters,
// the drain control, the read-address decode and the status outputs.
// Handshake: a requester raises req with addr/data and holds all three
// stable until it sees gnt=1; gnt=1 in a cycle means the write was taken
// at the rising edge that ends that cycle.
interface rf_write_arbiter_if #(
  parameter int NUM_REGS = 16,
  parameter int DATA_W   = 16
);
  localparam int ADDR_W = $clog2(NUM_REGS);

  logic              a_req;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_data;
  logic              a_gnt;
  logic              b_req;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_data;
  logic              b_gnt;
  logic              wr_hold;
  logic [ADDR_W-1:0] rd_addr1;
  logic [ADDR_W-1:0] rd_addr2;
  logic [NUM_REGS-1:0] ReadEnable1;
  logic [NUM_REGS-1:0] ReadEnable2;
  logic [NUM_REGS-1:0] WriteReg;
  logic [DATA_W-1:0] wr_data;
  logic              rd_hazard1;
  logic              rd_hazard2;
  logic [ADDR_W:0]   pending_cnt;

  // Requester / datapath side.
  modport master (
    output a_req, a_addr, a_data, b_req, b_addr, b_data,
           wr_hold, rd_addr1, rd_addr2,
    input  a_gnt, b_gnt, ReadEnable1, ReadEnable2, WriteReg, wr_data,
           rd_hazard1, rd_hazard2, pending_cnt
  );

  // Arbiter side.
  modport slave (
    input  a_req, a_addr, a_data, b_req, b_addr, b_data,
           wr_hold, rd_addr1, rd_addr2,
    output a_gnt, b_gnt, ReadEnable1, ReadEnable2, WriteReg, wr_data,
           rd_hazard1, rd_hazard2, pending_cnt
  );
endinterface

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter sharing the single register-file write port between
// requester A (execute) and requester B (load). Granted writes are queued
// in a small FIFO and drained one per cycle as a one-hot WriteReg word.
// Also decodes both read addresses and flags reads of registers that still
// have a write waiting in the FIFO.
module rf_write_arbiter #(
  parameter int NUM_REGS = 16,
  parameter int DATA_W   = 16,
  parameter int DEPTH    = 4
) (
  input logic clk,
  input logic rst,
  rf_write_arbiter_if.slave bus
);
  localparam int ADDR_W = $clog2(NUM_REGS);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int OCC_W  = ADDR_W + 1;

  function automatic logic [NUM_REGS-1:0] onehot(input logic [ADDR_W-1:0] a);
    onehot    = '0;
    onehot[a] = 1'b1;
  endfunction

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  cnt;
  logic              rr_b;        // 1 = B wins the next contested cycle
  logic              full, empty, push, pop;
  logic              a_gnt_c, b_gnt_c;
  logic [ADDR_W-1:0] push_addr;
  logic [DATA_W-1:0] push_data;
  logic [ADDR_W-1:0] head_addr;

  assign full      = (cnt == CNT_W'(DEPTH));
  assign empty     = (cnt == '0);
  assign pop       = !empty && !bus.wr_hold;
  assign head_addr = addr_mem[rd_ptr];

  // Grant decision: nothing is accepted when full, even on a popping cycle.
  always_comb begin
    a_gnt_c = 1'b0;
    b_gnt_c = 1'b0;
    if (!rst && !full) begin
      if (bus.a_req && bus.b_req) begin
        if (rr_b) b_gnt_c = 1'b1;
        else      a_gnt_c = 1'b1;
      end else if (bus.a_req) begin
        a_gnt_c = 1'b1;
      end else if (bus.b_req) begin
        b_gnt_c = 1'b1;
      end
    end
  end

  assign push      = a_gnt_c || b_gnt_c;
  assign push_addr = b_gnt_c ? bus.b_addr : bus.a_addr;
  assign push_data = b_gnt_c ? bus.b_data : bus.a_data;

  // FIFO pointers, occupancy and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      rr_b   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      // Only a contested grant hands priority to the other requester.
      if (push && bus.a_req && bus.b_req) rr_b <= ~rr_b;
    end
  end

  // FIFO storage; contents are don't-care while the slot is not valid.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr] <= push_addr;
      data_mem[wr_ptr] <= push_data;
    end
  end

  // Hazard scan over the valid FIFO slots; register 0 never hazards.
  always_comb begin
    logic [PTR_W-1:0] off;
    off            = '0;
    bus.rd_hazard1 = 1'b0;
    bus.rd_hazard2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      off = PTR_W'(i) - rd_ptr;
      if (CNT_W'(off) < cnt && addr_mem[i] != '0) begin
        if (addr_mem[i] == bus.rd_addr1) bus.rd_hazard1 = 1'b1;
        if (addr_mem[i] == bus.rd_addr2) bus.rd_hazard2 = 1'b1;
      end
    end
  end

  assign bus.a_gnt       = a_gnt_c;
  assign bus.b_gnt       = b_gnt_c;
  assign bus.pending_cnt = OCC_W'(cnt);
  assign bus.WriteReg    = (pop && head_addr != '0) ? onehot(head_addr) : '0;
  assign bus.wr_data     = empty ? '0 : data_mem[rd_ptr];
  // Read enables are held low in reset so the bitlines float.
  assign bus.ReadEnable1 = rst ? '0 : onehot(bus.rd_addr1);
  assign bus.ReadEnable2 = rst ? '0 : onehot(bus.rd_addr2);
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: scenario tasks plus a negedge scoreboard that
// models grants, FIFO contents, drains, hazards and read decode.
module tb_rf_write_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rf_write_arbiter_if #(.NUM_REGS(16), .DATA_W(16)) bus ();

  rf_write_arbiter #(.NUM_REGS(16), .DATA_W(16), .DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [19:0] exp_q[$];   // {addr, data} in expected retire order
  int n_cmp = 0;
  int n_err = 0;
  bit m_rr  = 1'b0;

  // Scoreboard state (monitor only)
  int          sz;
  logic [15:0] ew;
  logic [19:0] ent;
  logic        e_ag, e_bg, eh1, eh2;

  // Scoreboard: checks every cycle's outputs against the model, then advances it.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      m_rr = 1'b0;
    end else begin
      sz = exp_q.size();
      n_cmp++;
      if (bus.pending_cnt !== 5'(sz)) begin
        n_err++; $display("FAIL sb_pending_cnt got=%0d exp=%0d t=%0t", bus.pending_cnt, sz, $time);
      end
      eh1 = 1'b0; eh2 = 1'b0;
      foreach (exp_q[i]) begin
        if (exp_q[i][19:16] != 4'd0 && exp_q[i][19:16] == bus.rd_addr1) eh1 = 1'b1;
        if (exp_q[i][19:16] != 4'd0 && exp_q[i][19:16] == bus.rd_addr2) eh2 = 1'b1;
      end
      n_cmp++;
      if (bus.rd_hazard1 !== eh1 || bus.rd_hazard2 !== eh2) begin
        n_err++; $display("FAIL sb_hazard got=%b%b exp=%b%b t=%0t", bus.rd_hazard1, bus.rd_hazard2, eh1, eh2, $time);
      end
      ew = 16'h0001 << bus.rd_addr1;
      n_cmp++;
      if (bus.ReadEnable1 !== ew) begin
        n_err++; $display("FAIL sb_read_en1 got=%h exp=%h t=%0t", bus.ReadEnable1, ew, $time);
      end
      ew = 16'h0001 << bus.rd_addr2;
      n_cmp++;
      if (bus.ReadEnable2 !== ew) begin
        n_err++; $display("FAIL sb_read_en2 got=%h exp=%h t=%0t", bus.ReadEnable2, ew, $time);
      end
      e_ag = 1'b0; e_bg = 1'b0;
      if (sz < 4) begin
        if (bus.a_req && bus.b_req) begin
          if (m_rr) e_bg = 1'b1; else e_ag = 1'b1;
          m_rr = ~m_rr;
        end else if (bus.a_req) e_ag = 1'b1;
        else if (bus.b_req) e_bg = 1'b1;
      end
      n_cmp++;
      if (bus.a_gnt !== e_ag || bus.b_gnt !== e_bg) begin
        n_err++; $display("FAIL sb_grant got=a%b/b%b exp=a%b/b%b t=%0t", bus.a_gnt, bus.b_gnt, e_ag, e_bg, $time);
      end
      if (sz > 0) begin
        ent = exp_q[0];
        n_cmp++;
        if (bus.wr_data !== ent[15:0]) begin
          n_err++; $display("FAIL sb_wr_data got=%h exp=%h t=%0t", bus.wr_data, ent[15:0], $time);
        end
        if (!bus.wr_hold) begin
          ew = (ent[19:16] == 4'd0) ? 16'h0000 : (16'h0001 << ent[19:16]);
          void'(exp_q.pop_front());
        end else begin
          ew = 16'h0000;
        end
      end else begin
        ew = 16'h0000;
      end
      n_cmp++;
      if (bus.WriteReg !== ew) begin
        n_err++; $display("FAIL sb_write_reg got=%h exp=%h t=%0t", bus.WriteReg, ew, $time);
      end
      if (e_ag) exp_q.push_back({bus.a_addr, bus.a_data});
      if (e_bg) exp_q.push_back({bus.b_addr, bus.b_data});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Driver: present one write and hold it until granted (bounded wait).
  task automatic push(input bit to_b, input logic [3:0] addr, input logic [15:0] data);
    bit got = 1'b0;
    if (to_b) begin bus.b_req = 1'b1; bus.b_addr = addr; bus.b_data = data; end
    else      begin bus.a_req = 1'b1; bus.a_addr = addr; bus.a_data = data; end
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      got = to_b ? bus.b_gnt : bus.a_gnt;
      tick();
    end
    if (to_b) bus.b_req = 1'b0; else bus.a_req = 1'b0;
    if (!got) begin
      n_cmp++; n_err++;
      $display("FAIL push_timeout got=no_grant exp=grant addr=%0d", addr);
    end
  endtask

  task automatic test_reset();
    // Outputs while reset is held
    bus.a_req = 1'b1; bus.a_addr = 4'd2; bus.rd_addr1 = 4'd7; bus.rd_addr2 = 4'd9;
    @(negedge clk);
    n_cmp++;
    if (bus.pending_cnt !== 5'd0 || bus.WriteReg !== 16'h0 || bus.a_gnt !== 1'b0 ||
        bus.ReadEnable1 !== 16'h0 || bus.ReadEnable2 !== 16'h0 || bus.wr_data !== 16'h0) begin
      n_err++;
      $display("FAIL reset_outputs got=cnt%0d wr%h g%b re%h/%h d%h exp=all_zero",
               bus.pending_cnt, bus.WriteReg, bus.a_gnt, bus.ReadEnable1, bus.ReadEnable2, bus.wr_data);
    end
    tick();
    bus.a_req = 1'b0;
    rst = 1'b0;
    tick();
    // Reset while draining with three writes queued
    bus.wr_hold = 1'b1;
    push(1'b0, 4'd1, 16'h1111);
    push(1'b0, 4'd2, 16'h2222);
    push(1'b0, 4'd3, 16'h3333);
    bus.wr_hold = 1'b0;
    #2;
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus.pending_cnt !== 5'd0 || bus.WriteReg !== 16'h0) begin
      n_err++; $display("FAIL reset_mid_drain got=cnt%0d wr%h exp=cnt0 wr0000", bus.pending_cnt, bus.WriteReg);
    end
    tick();
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.pending_cnt !== 5'd0 || bus.WriteReg !== 16'h0) begin
        n_err++; $display("FAIL reset_discard got=cnt%0d wr%h exp=cnt0 wr0000", bus.pending_cnt, bus.WriteReg);
      end
      tick();
    end
  endtask

  task automatic test_single();
    bus.a_req = 1'b1; bus.a_addr = 4'd5; bus.a_data = 16'hBEEF;
    @(negedge clk);
    n_cmp++;
    if (bus.a_gnt !== 1'b1) begin
      n_err++; $display("FAIL single_gnt got=%b exp=1", bus.a_gnt);
    end
    tick();
    bus.a_req = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.WriteReg !== 16'h0020 || bus.wr_data !== 16'hBEEF) begin
      n_err++; $display("FAIL single_drain got=%h/%h exp=0020/beef", bus.WriteReg, bus.wr_data);
    end
    tick();
  endtask

  task automatic test_round_robin();
    int k = 0;
    bit ga, gb;
    apply_reset();
    bus.a_req = 1'b1; bus.a_addr = 4'd1; bus.a_data = 16'($urandom_range(0, 65535));
    bus.b_req = 1'b1; bus.b_addr = 4'd8; bus.b_data = 16'($urandom_range(0, 65535));
    for (int c = 0; c < 20 && k < 4; c++) begin
      @(negedge clk);
      ga = bus.a_gnt; gb = bus.b_gnt;
      if (ga || gb) begin
        n_cmp++;
        if (ga !== (k % 2 == 0) || gb !== (k % 2 == 1)) begin
          n_err++; $display("FAIL rr_order idx=%0d got=a%b/b%b exp=%s", k, ga, gb, (k % 2 == 0) ? "A" : "B");
        end
        k++;
      end
      tick();
      if (ga) begin bus.a_addr = bus.a_addr + 4'd1; bus.a_data = 16'($urandom_range(0, 65535)); end
      if (gb) begin bus.b_addr = bus.b_addr + 4'd1; bus.b_data = 16'($urandom_range(0, 65535)); end
    end
    bus.a_req = 1'b0; bus.b_req = 1'b0;
    if (k < 4) begin
      n_cmp++; n_err++; $display("FAIL rr_timeout got=%0d exp=4 grants", k);
    end
    repeat (4) tick();
  endtask

  task automatic test_full_hold();
    bus.wr_hold = 1'b1;
    for (int i = 0; i < 4; i++) push(1'b0, 4'(i + 1), 16'hA000 + 16'(i));
    bus.a_req = 1'b1; bus.a_addr = 4'd9; bus.a_data = 16'hA009;
    @(negedge clk);
    n_cmp++;
    if (bus.a_gnt !== 1'b0 || bus.pending_cnt !== 5'd4) begin
      n_err++; $display("FAIL full_block got=g%b cnt%0d exp=g0 cnt4", bus.a_gnt, bus.pending_cnt);
    end
    tick();
    bus.wr_hold = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.a_gnt !== 1'b0 || bus.WriteReg !== 16'h0002) begin
      n_err++; $display("FAIL full_pop_no_pass got=g%b wr%h exp=g0 wr0002", bus.a_gnt, bus.WriteReg);
    end
    tick();
    @(negedge clk);
    n_cmp++;
    if (bus.a_gnt !== 1'b1 || bus.pending_cnt !== 5'd3) begin
      n_err++; $display("FAIL full_regrant got=g%b cnt%0d exp=g1 cnt3", bus.a_gnt, bus.pending_cnt);
    end
    tick();
    bus.a_req = 1'b0;
    repeat (6) tick();
  endtask

  task automatic test_hazard();
    bus.wr_hold = 1'b1;
    push(1'b0, 4'd3, 16'h1234);
    bus.rd_addr1 = 4'd3; bus.rd_addr2 = 4'd4;
    @(negedge clk);
    n_cmp++;
    if (bus.rd_hazard1 !== 1'b1 || bus.rd_hazard2 !== 1'b0) begin
      n_err++; $display("FAIL hazard_set got=%b%b exp=10", bus.rd_hazard1, bus.rd_hazard2);
    end
    tick();
    bus.wr_hold = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.rd_hazard1 !== 1'b1 || bus.WriteReg !== 16'h0008 || bus.wr_data !== 16'h1234) begin
      n_err++; $display("FAIL hazard_drain got=h%b wr%h d%h exp=h1 wr0008 d1234", bus.rd_hazard1, bus.WriteReg, bus.wr_data);
    end
    tick();
    @(negedge clk);
    n_cmp++;
    if (bus.rd_hazard1 !== 1'b0) begin
      n_err++; $display("FAIL hazard_clear got=%b exp=0", bus.rd_hazard1);
    end
    tick();
  endtask

  task automatic test_zero_reg();
    bus.rd_addr1 = 4'd0; bus.rd_addr2 = 4'd0;
    bus.b_req = 1'b1; bus.b_addr = 4'd0; bus.b_data = 16'hFFFF;
    @(negedge clk);
    n_cmp++;
    if (bus.b_gnt !== 1'b1) begin
      n_err++; $display("FAIL zero_gnt got=%b exp=1", bus.b_gnt);
    end
    tick();
    bus.b_req = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.WriteReg !== 16'h0 || bus.pending_cnt !== 5'd1 || bus.rd_hazard1 !== 1'b0) begin
      n_err++; $display("FAIL zero_drain got=wr%h cnt%0d h%b exp=wr0000 cnt1 h0", bus.WriteReg, bus.pending_cnt, bus.rd_hazard1);
    end
    n_cmp++;
    if (bus.ReadEnable1 !== 16'h0001 || bus.ReadEnable2 !== 16'h0001) begin
      n_err++; $display("FAIL zero_read_en got=%h/%h exp=0001/0001", bus.ReadEnable1, bus.ReadEnable2);
    end
    tick();
  endtask

  task automatic test_random();
    bit ga = 1'b0, gb = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (!bus.a_req || ga) begin
        bus.a_req  = 1'($urandom_range(0, 1));
        bus.a_addr = 4'($urandom_range(0, 15));
        bus.a_data = 16'($urandom_range(0, 65535));
      end
      if (!bus.b_req || gb) begin
        bus.b_req  = 1'($urandom_range(0, 1));
        bus.b_addr = 4'($urandom_range(0, 15));
        bus.b_data = 16'($urandom_range(0, 65535));
      end
      bus.wr_hold  = ($urandom_range(0, 3) == 0);
      bus.rd_addr1 = 4'($urandom_range(0, 15));
      bus.rd_addr2 = 4'($urandom_range(0, 15));
      @(negedge clk);
      ga = bus.a_gnt; gb = bus.b_gnt;
      tick();
    end
    bus.a_req = 1'b0; bus.b_req = 1'b0; bus.wr_hold = 1'b0;
    repeat (6) tick();
  endtask

  initial begin
    bus.a_req = 1'b0; bus.a_addr = '0; bus.a_data = '0;
    bus.b_req = 1'b0; bus.b_addr = '0; bus.b_data = '0;
    bus.wr_hold = 1'b0; bus.rd_addr1 = '0; bus.rd_addr2 = '0;
    tick();
    test_reset();
    test_single();
    test_round_robin();
    test_full_hold();
    test_hazard();
    test_zero_reg();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
